readreg_bypass_stage: RTL and testbench
=======================================

// Module: readreg_bypass_stage
// PURPOSE
//  Parametrised register-read stage with a registered output slot. Reads source operands from the
//  physical register file and a configurable number of feedback bypass channels. It holds the resolved
//  group while issue stalls, and keeps snooping the feedback channels so held operands can still become loaded.
//  Sits between rename and issue. Carries an opaque per-lane payload through unchanged.
// PARAMETERS
//  LANES      2    ops per group (read width)
//  FB_CH      4    feedback channels (execute + writeback), index 0 = highest priority
//  PHY_ID_W   6    physical register id width
//  DATA_W     32   operand / immediate width
//  PAYLOAD_W  128  opaque per-lane payload width
// PORTS
//  clk              in   1                      clock
//  rst              in   1                      asynchronous reset, active-high
//  flush            in   1                      commit flush; drops held group
//  in_valid         in   LANES                  per-lane op valid from rename
//  in_ready         out  1                      group accepted at clock edge when in_ready & |in_valid
//  in_payload       in   LANES*PAYLOAD_W        opaque op payload
//  in_rs_phy        in   LANES*2*PHY_ID_W       source phy ids, [lane][src]
//  in_need_map      in   LANES*2                source reads a physical register
//  in_imm_sel       in   LANES*2                if !need_map: 1 = use imm, 0 = use zero
//  in_imm           in   LANES*DATA_W           per-lane immediate
//  phyf_id          out  LANES*2*PHY_ID_W       = in_rs_phy (combinational)
//  phyf_data        in   LANES*2*DATA_W         same-cycle register file read data
//  phyf_data_valid  in   LANES*2                register file value is ready
//  fb_enable        in   FB_CH                  feedback channel valid
//  fb_phy_id        in   FB_CH*PHY_ID_W         feedback destination id
//  fb_value         in   FB_CH*DATA_W           feedback data
//  out_valid        out  LANES                  per-lane held op valid
//  out_ready        in   1                      issue accepts held group
//  out_payload      out  LANES*PAYLOAD_W        held payload
//  out_src_value    out  LANES*2*DATA_W         held operand values
//  out_src_loaded   out  LANES*2                operand value is final
//  stall_cnt        out  32                     saturating count of stalled cycles
// BEHAVIOUR
//  - Reset (async): out_valid=0, out_src_loaded=0, out_src_value=0, out_payload=0, stall_cnt=0.
//  - Occupancy: occ = |out_valid. in_ready = !occ | out_ready (combinational).
//  - Accept (in_ready & |in_valid & !flush): one-cycle latency. Whole group is captured as a unit.
//    Lanes with in_valid=0 are captured with out_valid=0 and loaded=1.
//  - Resolve per operand at capture:
//    - need_map=0: value = imm_sel ? imm : 0; loaded=1.
//    - need_map=1 & phyf_data_valid: value = phyf_data; loaded=1.
//    - else if any fb ch has enable & id match: the lowest-index matching ch supplies value; loaded=1.
//    - else value=0, loaded=0.
//    - Priority is phyf over fb, then lowest channel index.
//  - Hold (occ & !out_ready): payload and valid are kept. Each cycle, every held operand with
//    need_map=1 & loaded=0 compares its stored phy id against fb channels. On a match the value and
//    loaded are updated at the edge. Loaded operands are never overwritten.
//  - Drain without refill (occ & out_ready & !(|in_valid)): out_valid -> 0 at the edge.
//  - Simultaneous drain + accept: the new group replaces the old one in the same edge (back-to-back,
//    no bubble).
//  - Flush: synchronous, highest priority. out_valid -> 0 and loaded -> 0 at the edge. The input group
//    in the flush cycle is discarded even if in_ready=1.
//  - stall_cnt: increments on each cycle with occ & !out_ready & !flush. Saturates at 2^32-1.
//    Cleared only by rst.
//  - Phy id compares are full-width equality. There is no special handling for id 0.
//  - Reset mid-hold: all held state is lost immediately (async). in_ready=1 after reset.
// TESTING
//  - Reset: assert rst mid-hold -> out_valid=0, loaded=0, stall_cnt=0, in_ready=1 on the same cycle.
//  - Capture: LANES=2, lane0 need_map=1, id=5, phyf_valid=1, data=0x11; lane1 src0 imm_sel=1,
//    imm=0x22 -> next cycle value 0x11 and 0x22, both loaded=1.
//  - Priority: id 9 not valid in phyf; fb ch1 and ch3 enabled for id 9 with 0xA/0xB
//    -> value 0xA, loaded=1.
//  - Stall snoop: capture id 7 unloaded, out_ready=0 for 3 cycles, fb ch2 (id 7, 0x77) in cycle 2
//    -> loaded=1 and value 0x77 from cycle 3; stall_cnt=3; a later fb on id 7 with 0x99 is ignored.
//  - Back-to-back: out_ready=1 and in_valid=11 for 4 cycles -> 4 groups out on consecutive cycles,
//    stall_cnt=0.
//  - Flush: flush with in_valid=11 and in_ready=1 -> out_valid=00 next cycle, input group dropped.

Source files
------------

// File: rtl/readreg_bypass_stage.sv
// readreg_bypass_stage
//   Register-read stage between rename and issue. A group of LANES ops, each
//   with two source operands, is resolved from three places:
//     - an immediate (or zero) when the source does not map to a register
//     - the same-cycle physical register file read
//     - the feedback bypass channels (lowest channel index wins)
//   The resolved group sits in one output slot. While issue stalls, operands
//   that are still waiting keep watching the feedback channels, so they can
//   become loaded while held. An opaque per-lane payload rides along unchanged.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   flush              drops the held group and any group offered this cycle
//   in_valid/in_ready  group handshake from rename (whole group moves as a unit)
//   in_payload         opaque per-lane payload
//   in_rs_phy          source physical ids, [lane][src]
//   in_need_map        source reads a physical register
//   in_imm_sel         for non-mapped sources: 1 = immediate, 0 = zero
//   in_imm             per-lane immediate
//   phyf_id            register file read ids (straight copy of in_rs_phy)
//   phyf_data(_valid)  same-cycle register file read data and readiness
//   fb_enable/phy_id/value  feedback bypass channels, index 0 highest priority
//   out_valid/out_ready     held group handshake towards issue
//   out_payload        held payload
//   out_src_value      held operand values
//   out_src_loaded     operand value is final
//   stall_cnt          saturating count of cycles the held group was stalled
module readreg_bypass_stage #(
  parameter int LANES     = 2,
  parameter int FB_CH     = 4,
  parameter int PHY_ID_W  = 6,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [LANES-1:0]            in_valid,
  output logic                        in_ready,
  input  logic [LANES*PAYLOAD_W-1:0]  in_payload,
  input  logic [LANES*2*PHY_ID_W-1:0] in_rs_phy,
  input  logic [LANES*2-1:0]          in_need_map,
  input  logic [LANES*2-1:0]          in_imm_sel,
  input  logic [LANES*DATA_W-1:0]     in_imm,
  output logic [LANES*2*PHY_ID_W-1:0] phyf_id,
  input  logic [LANES*2*DATA_W-1:0]   phyf_data,
  input  logic [LANES*2-1:0]          phyf_data_valid,
  input  logic [FB_CH-1:0]            fb_enable,
  input  logic [FB_CH*PHY_ID_W-1:0]   fb_phy_id,
  input  logic [FB_CH*DATA_W-1:0]     fb_value,
  output logic [LANES-1:0]            out_valid,
  input  logic                        out_ready,
  output logic [LANES*PAYLOAD_W-1:0]  out_payload,
  output logic [LANES*2*DATA_W-1:0]   out_src_value,
  output logic [LANES*2-1:0]          out_src_loaded,
  output logic [31:0]                 stall_cnt
);

  localparam int OPS = LANES * 2;

  logic                    occ;
  logic                    accept;
  logic [OPS*PHY_ID_W-1:0] held_phy;
  logic [OPS-1:0]          held_need_map;
  logic [OPS*DATA_W-1:0]   cap_value;
  logic [OPS-1:0]          cap_loaded;
  logic [OPS*DATA_W-1:0]   hold_value;
  logic [OPS-1:0]          hold_loaded;

  assign occ     = |out_valid;
  assign in_ready = !occ || out_ready;
  assign accept  = in_ready && (|in_valid) && !flush;
  assign phyf_id = in_rs_phy;

  // Operand resolution for the incoming group. The feedback scan runs from the
  // highest channel down so the lowest matching channel is the last writer.
  // Lanes without a valid op are marked loaded so they never snoop.
  always_comb begin
    cap_value  = '0;
    cap_loaded = '0;
    for (int op = 0; op < OPS; op++) begin
      if (!in_need_map[op]) begin
        cap_loaded[op] = 1'b1;
        if (in_imm_sel[op]) begin
          cap_value[op*DATA_W +: DATA_W] = in_imm[(op/2)*DATA_W +: DATA_W];
        end
      end else if (phyf_data_valid[op]) begin
        cap_loaded[op] = 1'b1;
        cap_value[op*DATA_W +: DATA_W] = phyf_data[op*DATA_W +: DATA_W];
      end else begin
        for (int ch = FB_CH - 1; ch >= 0; ch--) begin
          if (fb_enable[ch] &&
              fb_phy_id[ch*PHY_ID_W +: PHY_ID_W] == in_rs_phy[op*PHY_ID_W +: PHY_ID_W]) begin
            cap_loaded[op] = 1'b1;
            cap_value[op*DATA_W +: DATA_W] = fb_value[ch*DATA_W +: DATA_W];
          end
        end
      end
      if (!in_valid[op/2]) begin
        cap_loaded[op] = 1'b1;
      end
    end
  end

  // Snoop for held operands still waiting on a register. Already-loaded
  // operands pass through untouched.
  always_comb begin
    hold_value  = out_src_value;
    hold_loaded = out_src_loaded;
    for (int op = 0; op < OPS; op++) begin
      if (held_need_map[op] && !out_src_loaded[op]) begin
        for (int ch = FB_CH - 1; ch >= 0; ch--) begin
          if (fb_enable[ch] &&
              fb_phy_id[ch*PHY_ID_W +: PHY_ID_W] == held_phy[op*PHY_ID_W +: PHY_ID_W]) begin
            hold_loaded[op] = 1'b1;
            hold_value[op*DATA_W +: DATA_W] = fb_value[ch*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Output slot. Flush beats everything; a new group replaces a draining one
  // in the same edge; otherwise a held group only absorbs snooped operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= '0;
      out_payload    <= '0;
      out_src_value  <= '0;
      out_src_loaded <= '0;
      held_phy       <= '0;
      held_need_map  <= '0;
    end else if (flush) begin
      out_valid      <= '0;
      out_src_loaded <= '0;
    end else if (accept) begin
      out_valid      <= in_valid;
      out_payload    <= in_payload;
      out_src_value  <= cap_value;
      out_src_loaded <= cap_loaded;
      held_phy       <= in_rs_phy;
      held_need_map  <= in_need_map;
    end else if (occ && out_ready) begin
      out_valid <= '0;
    end else if (occ) begin
      out_src_value  <= hold_value;
      out_src_loaded <= hold_loaded;
    end
  end

  // Stall counter: sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (occ && !out_ready && !flush && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_readreg_bypass_stage.sv
// tb_readreg_bypass_stage
//   Drives directed scenarios followed by random traffic into
//   readreg_bypass_stage and compares every cycle against a behavioural model
//   of the output slot kept as plain arrays.
module tb_readreg_bypass_stage;

  localparam int LANES     = 2;
  localparam int FB_CH     = 4;
  localparam int PHY_ID_W  = 6;
  localparam int DATA_W    = 32;
  localparam int PAYLOAD_W = 128;
  localparam int OPS       = LANES * 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        flush;
  logic [LANES-1:0]            in_valid;
  logic                        in_ready;
  logic [LANES*PAYLOAD_W-1:0]  in_payload;
  logic [LANES*2*PHY_ID_W-1:0] in_rs_phy;
  logic [LANES*2-1:0]          in_need_map;
  logic [LANES*2-1:0]          in_imm_sel;
  logic [LANES*DATA_W-1:0]     in_imm;
  logic [LANES*2*PHY_ID_W-1:0] phyf_id;
  logic [LANES*2*DATA_W-1:0]   phyf_data;
  logic [LANES*2-1:0]          phyf_data_valid;
  logic [FB_CH-1:0]            fb_enable;
  logic [FB_CH*PHY_ID_W-1:0]   fb_phy_id;
  logic [FB_CH*DATA_W-1:0]     fb_value;
  logic [LANES-1:0]            out_valid;
  logic                        out_ready;
  logic [LANES*PAYLOAD_W-1:0]  out_payload;
  logic [LANES*2*DATA_W-1:0]   out_src_value;
  logic [LANES*2-1:0]          out_src_loaded;
  logic [31:0]                 stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the held slot
  bit                   m_valid  [LANES];
  logic [PAYLOAD_W-1:0] m_payload[LANES];
  logic [DATA_W-1:0]    m_value  [OPS];
  bit                   m_loaded [OPS];
  logic [PHY_ID_W-1:0]  m_phy    [OPS];
  bit                   m_need   [OPS];
  logic [31:0]          m_stall = '0;

  readreg_bypass_stage #(
    .LANES(LANES), .FB_CH(FB_CH), .PHY_ID_W(PHY_ID_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_rs_phy(in_rs_phy), .in_need_map(in_need_map), .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .phyf_id(phyf_id), .phyf_data(phyf_data), .phyf_data_valid(phyf_data_valid),
    .fb_enable(fb_enable), .fb_phy_id(fb_phy_id), .fb_value(fb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_src_value(out_src_value), .out_src_loaded(out_src_loaded), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // First enabled feedback channel (scanning up from 0) carrying this id
  function automatic bit fb_find(input logic [PHY_ID_W-1:0] id, output logic [DATA_W-1:0] v);
    v = '0;
    for (int ch = 0; ch < FB_CH; ch++) begin
      if (fb_enable[ch] && fb_phy_id[ch*PHY_ID_W +: PHY_ID_W] == id) begin
        v = fb_value[ch*DATA_W +: DATA_W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit model_occ();
    bit o = 1'b0;
    for (int l = 0; l < LANES; l++) o |= m_valid[l];
    return o;
  endfunction

  // Model update: what the slot must hold after each edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stall = '0;
      for (int l = 0; l < LANES; l++) begin
        m_valid[l] = 1'b0;
        m_payload[l] = '0;
      end
      for (int op = 0; op < OPS; op++) begin
        m_value[op] = '0;
        m_loaded[op] = 1'b0;
        m_phy[op] = '0;
        m_need[op] = 1'b0;
      end
    end else begin
      bit occ;
      logic [DATA_W-1:0] v;
      occ = model_occ();
      if (occ && !out_ready && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush) begin
        for (int l = 0; l < LANES; l++) m_valid[l] = 1'b0;
        for (int op = 0; op < OPS; op++) m_loaded[op] = 1'b0;
      end else if ((!occ || out_ready) && in_valid != '0) begin
        for (int l = 0; l < LANES; l++) begin
          m_valid[l] = in_valid[l];
          m_payload[l] = in_payload[l*PAYLOAD_W +: PAYLOAD_W];
          for (int s = 0; s < 2; s++) begin
            int op;
            op = l * 2 + s;
            m_phy[op] = in_rs_phy[op*PHY_ID_W +: PHY_ID_W];
            m_need[op] = in_need_map[op];
            if (!in_need_map[op]) begin
              m_value[op] = in_imm_sel[op] ? in_imm[l*DATA_W +: DATA_W] : '0;
              m_loaded[op] = 1'b1;
            end else if (phyf_data_valid[op]) begin
              m_value[op] = phyf_data[op*DATA_W +: DATA_W];
              m_loaded[op] = 1'b1;
            end else if (fb_find(m_phy[op], v)) begin
              m_value[op] = v;
              m_loaded[op] = 1'b1;
            end else begin
              m_value[op] = '0;
              m_loaded[op] = 1'b0;
            end
            if (!in_valid[l]) m_loaded[op] = 1'b1;
          end
        end
      end else if (occ && out_ready) begin
        for (int l = 0; l < LANES; l++) m_valid[l] = 1'b0;
      end else if (occ) begin
        for (int op = 0; op < OPS; op++) begin
          if (m_need[op] && !m_loaded[op] && fb_find(m_phy[op], v)) begin
            m_value[op] = v;
            m_loaded[op] = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: mid-cycle, inputs and outputs are both settled
  always @(negedge clk) begin
    if (!rst) begin
      bit occ;
      occ = model_occ();
      check_output("in_ready", 128'(in_ready), 128'(!occ || out_ready));
      check_output("phyf_id", 128'(phyf_id), 128'(in_rs_phy));
      check_output("stall_cnt", 128'(stall_cnt), 128'(m_stall));
      for (int l = 0; l < LANES; l++) begin
        check_output($sformatf("out_valid[%0d]", l), 128'(out_valid[l]), 128'(m_valid[l]));
        if (m_valid[l]) begin
          check_output($sformatf("out_payload[%0d]", l),
                       128'(out_payload[l*PAYLOAD_W +: PAYLOAD_W]), 128'(m_payload[l]));
          for (int s = 0; s < 2; s++) begin
            check_output($sformatf("out_src_value[%0d][%0d]", l, s),
                         128'(out_src_value[(l*2+s)*DATA_W +: DATA_W]), 128'(m_value[l*2+s]));
          end
        end
      end
      if (occ) begin
        for (int op = 0; op < OPS; op++) begin
          check_output($sformatf("out_src_loaded[%0d]", op),
                       128'(out_src_loaded[op]), 128'(m_loaded[op]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 1'b0;
    in_valid = '0;
    in_payload = '0;
    in_rs_phy = '0;
    in_need_map = '0;
    in_imm_sel = '0;
    in_imm = '0;
    phyf_data = '0;
    phyf_data_valid = '0;
    fb_enable = '0;
    fb_phy_id = '0;
    fb_value = '0;
  endtask

  task automatic set_fb(input int ch, input logic [PHY_ID_W-1:0] id, input logic [DATA_W-1:0] v);
    fb_enable[ch] = 1'b1;
    fb_phy_id[ch*PHY_ID_W +: PHY_ID_W] = id;
    fb_value[ch*DATA_W +: DATA_W] = v;
  endtask

  // Random group, feedback traffic and handshake; ids kept small so
  // feedback hits on held operands are common.
  task automatic apply_stimulus();
    flush = ($urandom_range(0, 19) == 0);
    in_valid = LANES'($urandom_range(0, 3));
    out_ready = ($urandom_range(0, 2) != 0);
    for (int l = 0; l < LANES; l++) begin
      in_payload[l*PAYLOAD_W +: PAYLOAD_W] = {$urandom, $urandom, $urandom, $urandom};
      in_imm[l*DATA_W +: DATA_W] = $urandom;
    end
    for (int op = 0; op < OPS; op++) begin
      in_rs_phy[op*PHY_ID_W +: PHY_ID_W] = PHY_ID_W'($urandom_range(0, 7));
      in_need_map[op] = 1'($urandom_range(0, 3) != 0);
      in_imm_sel[op] = 1'($urandom_range(0, 1));
      phyf_data_valid[op] = ($urandom_range(0, 2) == 0);
      phyf_data[op*DATA_W +: DATA_W] = $urandom;
    end
    for (int ch = 0; ch < FB_CH; ch++) begin
      fb_enable[ch] = ($urandom_range(0, 2) == 0);
      fb_phy_id[ch*PHY_ID_W +: PHY_ID_W] = PHY_ID_W'($urandom_range(0, 7));
      fb_value[ch*DATA_W +: DATA_W] = $urandom;
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_output("reset out_valid", 128'(out_valid), 128'(0));
    check_output("reset loaded", 128'(out_src_loaded), 128'(0));
    check_output("reset stall_cnt", 128'(stall_cnt), 128'(0));
    check_output("reset in_ready", 128'(in_ready), 128'(1));
    step();

    // Capture: register file read beats a matching feedback, imm select
    out_ready = 1'b1;
    in_valid = 2'b11;
    in_need_map[0] = 1'b1;
    in_rs_phy[0 +: PHY_ID_W] = 6'd5;
    phyf_data_valid[0] = 1'b1;
    phyf_data[0 +: DATA_W] = 32'h11;
    set_fb(0, 6'd5, 32'h55);
    in_imm_sel[2] = 1'b1;
    in_imm[DATA_W +: DATA_W] = 32'h22;
    step();
    check_output("capture value l0s0", 128'(out_src_value[0 +: DATA_W]), 128'(32'h11));
    check_output("capture value l1s0", 128'(out_src_value[2*DATA_W +: DATA_W]), 128'(32'h22));
    check_output("capture loaded", 128'(out_src_loaded), 128'(4'b1111));
    clear_inputs();
    step();

    // Feedback priority: lowest matching channel wins when phyf is not ready
    in_valid = 2'b01;
    in_need_map[0] = 1'b1;
    in_rs_phy[0 +: PHY_ID_W] = 6'd9;
    phyf_data[0 +: DATA_W] = 32'hDEAD;
    set_fb(0, 6'd3, 32'hC);
    set_fb(1, 6'd9, 32'hA);
    set_fb(3, 6'd9, 32'hB);
    step();
    check_output("priority value", 128'(out_src_value[0 +: DATA_W]), 128'(32'hA));
    check_output("priority out_valid", 128'(out_valid), 128'(2'b01));
    check_output("priority loaded", 128'(out_src_loaded), 128'(4'b1111));
    clear_inputs();
    step();

    // Stall snoop: id 7 waits, feedback arrives on the second stall cycle
    in_valid = 2'b01;
    in_need_map[0] = 1'b1;
    in_rs_phy[0 +: PHY_ID_W] = 6'd7;
    out_ready = 1'b0;
    step();
    clear_inputs();
    check_output("snoop initial loaded", 128'(out_src_loaded[0]), 128'(0));
    step();
    check_output("snoop stall 1", 128'(stall_cnt), 128'(1));
    set_fb(2, 6'd7, 32'h77);
    step();
    check_output("snoop loaded", 128'(out_src_loaded[0]), 128'(1));
    check_output("snoop value", 128'(out_src_value[0 +: DATA_W]), 128'(32'h77));
    clear_inputs();
    set_fb(2, 6'd7, 32'h99);
    step();
    check_output("snoop no overwrite", 128'(out_src_value[0 +: DATA_W]), 128'(32'h77));
    check_output("snoop stall 3", 128'(stall_cnt), 128'(3));
    clear_inputs();
    out_ready = 1'b1;
    step();
    check_output("snoop drained", 128'(out_valid), 128'(0));

    // Back-to-back: four groups on consecutive edges, no stall
    for (int k = 0; k < 4; k++) begin
      in_valid = 2'b11;
      in_imm_sel = 4'b1111;
      in_imm = {32'h200 + 32'(k), 32'h100 + 32'(k)};
      step();
      check_output($sformatf("b2b out_valid %0d", k), 128'(out_valid), 128'(2'b11));
      check_output($sformatf("b2b lane0 %0d", k), 128'(out_src_value[0 +: DATA_W]),
                   128'(32'h100 + 32'(k)));
      check_output($sformatf("b2b lane1 %0d", k), 128'(out_src_value[2*DATA_W +: DATA_W]),
                   128'(32'h200 + 32'(k)));
    end
    check_output("b2b stall_cnt", 128'(stall_cnt), 128'(3));
    clear_inputs();
    step();

    // Flush drops the held group and the group offered with it
    in_valid = 2'b11;
    out_ready = 1'b0;
    step();
    in_valid = 2'b11;
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    check_output("flush out_valid", 128'(out_valid), 128'(0));
    check_output("flush loaded", 128'(out_src_loaded), 128'(0));
    clear_inputs();
    step();
    check_output("flush stays empty", 128'(out_valid), 128'(0));

    // Reset in the middle of a hold
    in_valid = 2'b10;
    out_ready = 1'b0;
    step();
    clear_inputs();
    step();
    check_output("hold stall_cnt", 128'(stall_cnt), 128'(4));
    #1 rst = 1'b1;
    #1;
    check_output("midhold out_valid", 128'(out_valid), 128'(0));
    check_output("midhold loaded", 128'(out_src_loaded), 128'(0));
    check_output("midhold stall_cnt", 128'(stall_cnt), 128'(0));
    check_output("midhold in_ready", 128'(in_ready), 128'(1));
    #1 rst = 1'b0;
    step();

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus();
      step();
    end
    clear_inputs();
    out_ready = 1'b1;
    repeat (3) step();

    $display("[TB] random phase complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
